// File: rtl/pkt_in_fifo.sv
// Store-and-forward packet FIFO feeding one input of the CPU merge stage.
// Packets are released only after their EOP word is stored; overflowing packets are discarded whole.
module pkt_in_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic [15:0]           drop_count
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned WORD_W = DATA_WIDTH + CTRL_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DROP    = 2'd3
    } in_state_t;

    logic [WORD_W-1:0]     mem [DEPTH];
    logic [WORD_W-1:0]     head;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] pkt_start;
    logic [CNT_W-1:0]      word_count;
    logic [CNT_W-1:0]      word_count_nxt;
    logic [CNT_W-1:0]      pkt_len;
    logic [CNT_W-1:0]      free_slots;
    in_state_t             state;
    in_state_t             state_nxt;
    logic                  prev_payload;

    logic full;
    logic in_ctrl_nz;
    logic pop;
    logic pop_eop;
    logic store;
    logic eop_store;
    logic rewind;
    logic drop_evt;

    // Status derived from registered counters
    assign full       = (word_count == CNT_W'(DEPTH));
    assign empty      = (word_count == '0);
    assign free_slots = CNT_W'(DEPTH) - word_count;
    assign in_rdy     = (free_slots > CNT_W'(AF_MARGIN));
    assign in_ctrl_nz = (in_ctrl != '0);

    // First-word fall-through head; pops only ever touch complete packets
    assign head     = mem[rd_ptr];
    assign out_data = head[DATA_WIDTH-1:0];
    assign out_ctrl = head[WORD_W-1 -: CTRL_WIDTH];
    assign pop      = out_rdy && (pkt_count != '0);
    assign out_wr   = pop;
    assign pop_eop  = pop && (out_ctrl != '0) && prev_payload;

    // Write-side decode: what happens to the incoming word this cycle
    always_comb begin
        store     = 1'b0;
        eop_store = 1'b0;
        rewind    = 1'b0;
        drop_evt  = 1'b0;
        state_nxt = state;
        if (in_wr) begin
            case (state)
                S_IDLE: begin
                    if (in_ctrl_nz) begin
                        if (full) begin
                            drop_evt  = 1'b1;
                            state_nxt = S_DROP;
                        end else begin
                            store     = 1'b1;
                            state_nxt = S_HDR;
                        end
                    end
                end
                S_HDR: begin
                    if (full) begin
                        rewind    = 1'b1;
                        drop_evt  = 1'b1;
                        state_nxt = S_DROP;
                    end else begin
                        store = 1'b1;
                        if (!in_ctrl_nz) begin
                            state_nxt = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (full) begin
                        rewind   = 1'b1;
                        drop_evt = 1'b1;
                        // A lost EOP already closes the packet, so there is nothing left to skip
                        state_nxt = in_ctrl_nz ? S_IDLE : S_DROP;
                    end else begin
                        store = 1'b1;
                        if (in_ctrl_nz) begin
                            eop_store = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (in_ctrl_nz) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Rewind returns the partial packet's words before counting this cycle's push/pop
    always_comb begin
        word_count_nxt = word_count - (rewind ? pkt_len : '0)
                       + CNT_W'(store) - CNT_W'(pop);
    end

    // Packet storage; contents survive reset
    always_ff @(posedge clk) begin
        if (store && !reset) begin
            mem[wr_ptr] <= {in_ctrl, in_data};
        end
    end

    // Input FSM, pointers and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pkt_start    <= '0;
            pkt_len      <= '0;
            word_count   <= '0;
            pkt_count    <= '0;
            drop_count   <= '0;
            prev_payload <= 1'b0;
        end else begin
            state      <= state_nxt;
            word_count <= word_count_nxt;
            pkt_count  <= pkt_count + CNT_W'(eop_store) - CNT_W'(pop_eop);

            if (rewind) begin
                wr_ptr  <= pkt_start;
                pkt_len <= '0;
            end else if (store) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                if (state == S_IDLE) begin
                    pkt_start <= wr_ptr;
                    pkt_len   <= CNT_W'(1);
                end else begin
                    pkt_len <= pkt_len + CNT_W'(1);
                end
            end

            if (drop_evt && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end

            if (pop) begin
                rd_ptr       <= rd_ptr + ADDR_WIDTH'(1);
                prev_payload <= (out_ctrl == '0);
            end
        end
    end

endmodule

// File: tb/tb_pkt_in_fifo.sv
// Directed bench for pkt_in_fifo: scoreboard queue filled on write, drained on out_wr.
module tb_pkt_in_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        empty;
    logic [5:0]  pkt_count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    logic [71:0] q[$];
    bit  t5_on = 1'b0;
    int  t5_max_pkt = 0;
    int  t5_words = 0;

    pkt_in_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_wr      (in_wr),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .empty      (empty),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every popped word must match the scoreboard head
    always @(negedge clk) begin
        if (!reset && out_wr) begin
            chk("pop_expected", 80'(q.size() != 0), 80'd1);
            if (q.size() != 0) begin
                chk("pop_word", 80'({out_ctrl, out_data}), 80'(q.pop_front()));
            end
            if (t5_on) t5_words++;
        end
        if (t5_on && int'(pkt_count) > t5_max_pkt) t5_max_pkt = int'(pkt_count);
    end

    task automatic wr(input logic [7:0] c, input logic [63:0] d, input bit exp);
        @(posedge clk); #1;
        in_wr   = 1'b1;
        in_ctrl = c;
        in_data = d;
        if (exp) q.push_back({c, d});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_wr = 1'b0;
        end
    endtask

    task automatic send_pkt(input int nwords, input bit exp, input logic [63:0] seed);
        wr(8'hFF, seed, exp);
        for (int i = 1; i < nwords - 1; i++) wr(8'h00, seed + 64'(i), exp);
        wr(8'h01, seed + 64'(nwords - 1), exp);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        chk("drain_done", 80'(q.size()), 80'd0);
        @(negedge clk);
        chk("drain_pkt_count", 80'(pkt_count), 80'd0);
        chk("drain_out_wr", 80'(out_wr), 80'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_wr = 1'b0; in_ctrl = '0; in_data = '0; out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_empty", 80'(empty), 80'd1);
        chk("rst_pkt_count", 80'(pkt_count), 80'd0);
        chk("rst_in_rdy", 80'(in_rdy), 80'd1);
        chk("rst_out_wr", 80'(out_wr), 80'd0);
        chk("rst_drop_count", 80'(drop_count), 80'd0);

        // T1: 4-word packet with sink ready
        send_pkt(4, 1'b1, 64'h1000);
        idle(1);
        @(negedge clk);
        chk("t1_pkt_count", 80'(pkt_count), 80'd1);
        chk("t1_out_wr", 80'(out_wr), 80'd1);
        drain(20);
        chk("t1_empty", 80'(empty), 80'd1);

        // T2: sink held off after packet completes
        out_rdy = 1'b0;
        send_pkt(4, 1'b1, 64'h2000);
        idle(10);
        @(negedge clk);
        chk("t2_out_wr", 80'(out_wr), 80'd0);
        chk("t2_pkt_count", 80'(pkt_count), 80'd1);
        chk("t2_empty", 80'(empty), 80'd0);
        @(posedge clk); #1 out_rdy = 1'b1;
        drain(20);

        // T3: oversize packet dropped, next packet unaffected
        send_pkt(40, 1'b0, 64'h3000);
        idle(1);
        @(negedge clk);
        chk("t3_drop_count", 80'(drop_count), 80'd1);
        chk("t3_pkt_count", 80'(pkt_count), 80'd0);
        chk("t3_empty", 80'(empty), 80'd1);
        send_pkt(4, 1'b1, 64'h3100);
        idle(1);
        drain(20);

        // T4: complete packet survives a later packet's overflow
        out_rdy = 1'b0;
        send_pkt(6, 1'b1, 64'h4000);
        send_pkt(40, 1'b0, 64'h4100);
        idle(1);
        @(negedge clk);
        chk("t4_drop_count", 80'(drop_count), 80'd2);
        chk("t4_pkt_count", 80'(pkt_count), 80'd1);
        chk("t4_empty", 80'(empty), 80'd0);
        chk("t4_in_rdy", 80'(in_rdy), 80'd1);
        @(posedge clk); #1 out_rdy = 1'b1;
        drain(30);

        // T5: continuous streaming of 3-word packets
        t5_on = 1'b1;
        for (int p = 0; p < 100; p++) send_pkt(3, 1'b1, 64'h5000 + 64'(p * 4));
        idle(1);
        drain(100);
        t5_on = 1'b0;
        chk("t5_words_out", 80'(t5_words), 80'd300);
        chk("t5_max_pkt_le2", 80'(t5_max_pkt <= 2), 80'd1);
        chk("t5_drop_count", 80'(drop_count), 80'd2);

        // T6: reset while both sides are mid-packet
        out_rdy = 1'b0;
        send_pkt(6, 1'b1, 64'h6000);
        wr(8'hFF, 64'h6100, 1'b0);
        out_rdy = 1'b1;
        wr(8'h00, 64'h6101, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1; in_wr = 1'b1; in_ctrl = 8'h00; in_data = 64'h6102;
        @(posedge clk); #1;
        reset = 1'b0; in_wr = 1'b0;
        q.delete();
        @(negedge clk);
        chk("t6_empty", 80'(empty), 80'd1);
        chk("t6_pkt_count", 80'(pkt_count), 80'd0);
        chk("t6_in_rdy", 80'(in_rdy), 80'd1);
        chk("t6_out_wr", 80'(out_wr), 80'd0);
        chk("t6_drop_count", 80'(drop_count), 80'd0);
        wr(8'h00, 64'h6200, 1'b0);
        wr(8'h00, 64'h6201, 1'b0);
        idle(1);
        @(negedge clk);
        chk("t6_lead_payload_ignored", 80'(empty), 80'd1);
        send_pkt(4, 1'b1, 64'h6300);
        idle(1);
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
